// File: rtl/shift_right_seq_if.sv
// shift_right_seq_if: request/result bundle for the sequential right shifter
interface shift_right_seq_if #(
   parameter int WIDTH = 8,
   parameter int SW    = 3
);
   logic             start_i;
   logic [WIDTH-1:0] a_i;
   logic [SW-1:0]    s_i;
   logic             arith_i;
`ifdef SHR_ROTATE_EN
   logic             rot_i;
`endif
   logic             busy_o;
   logic             done_o;
   logic [WIDTH-1:0] y_o;

`ifdef SHR_ROTATE_EN
   modport master (output start_i, a_i, s_i, arith_i, rot_i, input busy_o, done_o, y_o);
   modport slave  (input start_i, a_i, s_i, arith_i, rot_i, output busy_o, done_o, y_o);
`else
   modport master (output start_i, a_i, s_i, arith_i, input busy_o, done_o, y_o);
   modport slave  (input start_i, a_i, s_i, arith_i, output busy_o, done_o, y_o);
`endif
endinterface

// File: rtl/shift_right_seq.sv
// shift_right_seq: one-bit-per-clock right shifter (logical/arithmetic; rotate with SHR_ROTATE_EN)
module shift_right_seq #(
   parameter int WIDTH = 8,
   parameter int SW    = 3
) (
   input logic              CLK,
   input logic              RST,
   shift_right_seq_if.slave bus
);
   typedef enum logic [1:0] {IDLE, SHIFT, FIN} state_t;

   state_t           state_q, state_d;
   logic [WIDTH-1:0] y_q, y_d;
   logic [SW-1:0]    cnt_q, cnt_d;
   logic             arith_q, arith_d;
   logic             fill;
`ifdef SHR_ROTATE_EN
   logic             rot_q, rot_d;
`endif

   // state, result, remaining count and captured mode bits
   always_ff @(posedge CLK) begin
      if (RST) begin
         state_q <= IDLE;
         y_q     <= '0;
         cnt_q   <= '0;
         arith_q <= 1'b0;
`ifdef SHR_ROTATE_EN
         rot_q   <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         y_q     <= y_d;
         cnt_q   <= cnt_d;
         arith_q <= arith_d;
`ifdef SHR_ROTATE_EN
         rot_q   <= rot_d;
`endif
      end
   end

   // capture on START in IDLE, shift one bit per SHIFT cycle, pulse DONE in FIN
   always_comb begin
      state_d = state_q;
      y_d     = y_q;
      cnt_d   = cnt_q;
      arith_d = arith_q;
`ifdef SHR_ROTATE_EN
      rot_d   = rot_q;
      fill    = rot_q ? y_q[0] : (arith_q & y_q[WIDTH-1]);
`else
      fill    = arith_q & y_q[WIDTH-1];
`endif
      if (state_q == IDLE && bus.start_i) begin
         y_d     = bus.a_i;
         cnt_d   = bus.s_i;
         arith_d = bus.arith_i;
`ifdef SHR_ROTATE_EN
         rot_d   = bus.rot_i;
`endif
         state_d = (bus.s_i == '0) ? FIN : SHIFT;
      end else if (state_q == SHIFT) begin
         y_d     = {fill, y_q[WIDTH-1:1]};
         cnt_d   = cnt_q - SW'(1);
         state_d = (cnt_q == SW'(1)) ? FIN : SHIFT;
      end else if (state_q == FIN) begin
         state_d = IDLE;
      end
   end

   assign bus.busy_o = (state_q == SHIFT);
   assign bus.done_o = (state_q == FIN);
   assign bus.y_o    = y_q;
endmodule
